// File: rtl/register_bank_if.sv
// Register-file port bundle: one write port from write-back, two read ports to decode.
// master = pipeline side (drives write and read addresses), slave = register_bank.
interface register_bank_if #(
  parameter int NBITS  = 32,
  parameter int ADDR_W = 5
) ();
  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [NBITS-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [NBITS-1:0]  rd_data_a;
  logic [NBITS-1:0]  rd_data_b;

  modport master (
    output reg_write, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  reg_write, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/register_bank.sv
// Integer register file: one write port, two combinational read ports, r0 hardwired to zero.
// Optional same-cycle write-through bypass selected by macro REGBANK_BYPASS_EN.
module register_bank #(
  parameter int NBITS  = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  register_bank_if.slave bus
);

  logic [NBITS-1:0] regs_r [NREGS];
  logic [NREGS-1:1] we_s;
  logic [NBITS-1:0] array_a_s;
  logic [NBITS-1:0] array_b_s;

  // One-hot write decode; a low reg_write masks X on wr_addr so no register is touched.
  always_comb begin
    we_s = '0;
    for (int i = 1; i < NREGS; i++) begin
      we_s[i] = bus.reg_write & (bus.wr_addr == ADDR_W'(i));
    end
  end

  // Register storage; entry 0 is held at zero and never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      regs_r[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (we_s[i]) begin
          regs_r[i] <= bus.wr_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Plain array read with the r0 zero override.
  always_comb begin
    if (bus.rd_addr_a == '0) begin
      array_a_s = '0;
    end else begin
      array_a_s = regs_r[bus.rd_addr_a];
    end
    if (bus.rd_addr_b == '0) begin
      array_b_s = '0;
    end else begin
      array_b_s = regs_r[bus.rd_addr_b];
    end
  end

`ifdef REGBANK_BYPASS_EN
  // In-flight write matches a read address; suppressed while reset is held so reads stay zero.
  function automatic logic bypass_hit(
    input logic              rst_ok,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [ADDR_W-1:0] ra
  );
    return rst_ok & wen & (wa != '0) & (wa == ra);
  endfunction

  assign bus.rd_data_a = bypass_hit(reset_n, bus.reg_write, bus.wr_addr, bus.rd_addr_a)
                         ? bus.wr_data : array_a_s;
  assign bus.rd_data_b = bypass_hit(reset_n, bus.reg_write, bus.wr_addr, bus.rd_addr_b)
                         ? bus.wr_data : array_b_s;
`else
  assign bus.rd_data_a = array_a_s;
  assign bus.rd_data_b = array_b_s;
`endif

endmodule
